// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_mult_state_t;

    // Ones in every column at or above k, limited to `width` bits (width <= 64).
    function automatic logic [63:0] trunc_mask(input int width, input int k);
        logic [63:0] m;
        m = {64{1'b1}} << k;
        if (width < 64)
            m = m & ((64'd1 << width) - 64'd1);
        return m;
    endfunction

endpackage

// File: rtl/seq_shift_add_mult.sv
// Sequential M x N unsigned shift-and-add multiplier with valid/ready handshakes.
// Define SEQ_MULT_APPROX_TRUNC_EN to drop partial-product columns below K.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M+N-1:0] out_product
);

    localparam int W = M + N;

`ifdef SEQ_MULT_APPROX_TRUNC_EN
    localparam logic [W-1:0] PP_MASK = W'(trunc_mask(W, K));
`else
    localparam logic [W-1:0] PP_MASK = {W{1'b1}};
`endif

    seq_mult_state_t state;
    logic [W-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic [W-1:0]    acc;
    logic [W-1:0]    pp;
    logic [N-1:0]    b_next;

    always_comb begin
        pp     = b_sh[0] ? (a_sh & PP_MASK) : '0;
        b_next = b_sh >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= {{N{1'b0}}, in_a};
                        b_sh  <= in_b;
                        acc   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc + pp;
                    a_sh <= a_sh << 1;
                    b_sh <= b_next;
                    // Stop as soon as no multiplier bits remain; always at least one cycle.
                    if (b_next == '0)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign out_product = acc;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed + exhaustive bench for seq_shift_add_mult with a scoreboard queue.
module tb_seq_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_product;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [5:0]  s_in_a, s_in_b;
    logic [11:0] s_out_product;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    seq_shift_add_mult #(.M(8), .N(8), .K(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product)
    );

    seq_shift_add_mult #(.M(6), .N(6), .K(4)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_product(s_out_product)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Approximate result: sum of shifted multiplicands with columns below 4 cleared.
    function automatic logic [31:0] approx6(input logic [5:0] a, input logic [5:0] b);
        logic [31:0] s = 0;
        for (int i = 0; i < 6; i++)
            if (b[i]) s += ((32'(a) << i) & 32'hFF0);
        return s & 32'hFFF;
    endfunction

    // All helpers run on the posedge+1 phase.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [31:0] exp);
        int n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b;
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic drain(input string tag);
        logic [31:0] e;
        chk({tag, "_sb"}, {31'd0, sb.size() != 0}, 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD;
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_prod"}, {16'd0, out_product}, e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; out_ready = 0; in_a = 0; in_b = 0;
        s_in_valid = 0; s_out_ready = 0; s_in_a = 0; s_in_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_prod", {16'd0, out_product}, 32'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef SEQ_MULT_APPROX_TRUNC_EN
        send(8'hFF, 8'hFF, 32'hFDD0);
`else
        send(8'hFF, 8'hFF, 32'hFE01);
`endif
        wait_out("ffff", 8); drain("ffff");

`ifdef SEQ_MULT_APPROX_TRUNC_EN
        send(8'h5A, 8'h01, 32'h0050);
`else
        send(8'h5A, 8'h01, 32'h005A);
`endif
        wait_out("x01", 1); drain("x01");

        send(8'h5A, 8'h00, 32'h0000);
        wait_out("x00", 1); drain("x00");

        send(8'h03, 8'h10, 32'h0030);
        wait_out("x10", 5); drain("x10");

        // Backpressure with the source holding the next pair on in_valid.
`ifdef SEQ_MULT_APPROX_TRUNC_EN
        send(8'h12, 8'h34, 32'h03A0);
`else
        send(8'h12, 8'h34, 32'h03A8);
`endif
        in_valid = 1'b1; in_a = 8'h03; in_b = 8'h05;
        wait_out("bp", 6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
`ifdef SEQ_MULT_APPROX_TRUNC_EN
            chk("bp_hold_prod", {16'd0, out_product}, 32'h03A0);
`else
            chk("bp_hold_prod", {16'd0, out_product}, 32'h03A8);
`endif
        end
        drain("bp");
        @(posedge clk); #1;
        chk("bp_accept", {31'd0, in_ready}, 32'd0);
`ifdef SEQ_MULT_APPROX_TRUNC_EN
        sb.push_back(32'h0000);
`else
        sb.push_back(32'h000F);
`endif
        in_valid = 1'b0;
        wait_out("bp2", 3); drain("bp2");

        // Reset during the third BUSY cycle discards the operation.
        send(8'hFF, 8'hFF, 32'hFE01);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_prod", {16'd0, out_product}, 32'h0000);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`ifdef SEQ_MULT_APPROX_TRUNC_EN
        send(8'h03, 8'h05, 32'h0000);
`else
        send(8'h03, 8'h05, 32'h000F);
`endif
        wait_out("post_rst", 3); drain("post_rst");

        // Exhaustive 6x6 sweep.
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                logic [31:0] e;
                int n;
`ifdef SEQ_MULT_APPROX_TRUNC_EN
                sb.push_back(approx6(6'(a), 6'(b)));
`else
                sb.push_back(32'(a * b));
`endif
                s_in_valid = 1'b1; s_in_a = 6'(a); s_in_b = 6'(b);
                @(posedge clk); #1;
                s_in_valid = 1'b0;
                n = 0;
                while (!s_out_valid && n < 20) begin @(posedge clk); #1; n++; end
                e = sb.pop_front();
                chk("sweep", {20'd0, s_out_product}, e);
`ifdef SEQ_MULT_APPROX_TRUNC_EN
                chk("sweep_le", {31'd0, 32'(s_out_product) <= 32'(a * b)}, 32'd1);
                chk("sweep_low", {28'd0, s_out_product[3:0]}, 32'd0);
`endif
                s_out_ready = 1'b1;
                @(posedge clk); #1;
                s_out_ready = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
